ipf_seq: RTL and testbench

- Hardware sequencer that drives the IPF convolution engine's load/stream protocol, which the bench currently generates by hand.
- Loads one weight set from a weight buffer, then streams input-row tiles from an input buffer. While streaming it drives ctrl (start/hold/end), wgroup and wround.
- Supports parametrised tile depth, 3x3 or 5x5 kernels, stride 1/2, and a run-time number of segments and passes.
- Sits between the row/weight SRAMs and the IPF instance.

---
 rtl/ipf_seq.sv | 156 +++++++++++++++
 tb/tb_ipf_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ipf_seq.sv
// ipf_seq: sequencer driving the IPF weight-load / row-stream protocol.
// Optional perf counters (perf_cycles, perf_rows) enabled by IPF_SEQ_PERF_EN.
module ipf_seq #(
    parameter int DATA_W   = 64,
    parameter int I_ROWS   = 8,
    parameter int IA_W     = 3,
    parameter int W3_WORDS = 18,
    parameter int W5_WORDS = 25,
    parameter int WA_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_wsize,
    input  logic              cfg_stride,
    input  logic [3:0]        cfg_segs,
    input  logic [3:0]        cfg_passes,
    output logic [WA_W-1:0]   w_rd_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic [IA_W-1:0]   i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [1:0]        ipf_ctrl,
    output logic              ipf_w_valid,
    output logic [DATA_W-1:0] ipf_w_data,
    output logic              ipf_i_valid,
    output logic [DATA_W-1:0] ipf_i_data,
    output logic [1:0]        ipf_wsize,
    output logic              ipf_stride,
    output logic [3:0]        ipf_wgroup,
    output logic [2:0]        ipf_wround,
    input  logic              ipf_finish,
    output logic              busy,
    output logic              done
`ifdef IPF_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [15:0]       perf_rows
`endif
);
    localparam int RW = $clog2(15 * I_ROWS + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, PRIME, RUN, END, WAIT_FIN} state_t;

    state_t          state, nxt;
    logic            k5, stride_r, tg;
    logic [3:0]      segs_r, passes_r, seg;
    logic [WA_W-1:0] w_cnt;
    logic [RW-1:0]   row, total_m1;
    logic [IA_W-1:0] i_addr;
    logic            w_valid_q, i_valid_q, done_q;
    logic [1:0]      ctrl_q, ctrl_n;
    logic [3:0]      wgroup_q, wgroup_n;
    logic [2:0]      wround_q, wround_n;
    logic            accept, streaming, last_w, last_row, prime_end, last_seg;

    assign accept    = cfg_valid && state == IDLE;
    assign streaming = state == PRIME || state == RUN;
    assign last_w    = w_cnt == (k5 ? WA_W'(W5_WORDS - 1) : WA_W'(W3_WORDS - 1));
    assign total_m1  = RW'(passes_r) * RW'(I_ROWS) - RW'(1);
    assign last_row  = row == total_m1;
    assign prime_end = row == (k5 ? RW'(3) : RW'(1));
    assign last_seg  = seg == segs_r - 4'd1;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (cfg_valid) nxt = LOAD_W;
            LOAD_W:   if (last_w) nxt = PRIME;
            PRIME:    if (prime_end) nxt = RUN;
            RUN:      if (last_row) nxt = last_seg ? END : PRIME;
            END:      nxt = WAIT_FIN;
            WAIT_FIN: if (ipf_finish) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Next values of the input-side pipeline; all register together one cycle behind i_rd_addr
    always_comb begin
        ctrl_n   = state == PRIME ? (seg == 4'd0 ? 2'd3 : 2'd2) :
                   state == RUN ? 2'd1 :
                   (state == END || state == WAIT_FIN) ? 2'd0 : 2'd3;
        wgroup_n = (!streaming || k5) ? 4'd0 :
                   stride_r ? {3'b0, state == RUN && tg} : seg;
        wround_n = (streaming && k5) ? {2'b0, seg[0]} : 3'd0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            k5        <= 1'b0;
            stride_r  <= 1'b0;
            segs_r    <= 4'd1;
            passes_r  <= 4'd1;
            w_cnt     <= '0;
            row       <= '0;
            i_addr    <= '0;
            seg       <= 4'd0;
            tg        <= 1'b0;
            w_valid_q <= 1'b0;
            i_valid_q <= 1'b0;
            ctrl_q    <= 2'd3;
            wgroup_q  <= 4'd0;
            wround_q  <= 3'd0;
            done_q    <= 1'b0;
        end else begin
            if (accept) begin
                k5       <= cfg_wsize == 2'd1;
                stride_r <= cfg_stride && cfg_wsize != 2'd1;
                segs_r   <= cfg_segs == 4'd0 ? 4'd1 : cfg_segs;
                passes_r <= cfg_passes == 4'd0 ? 4'd1 : cfg_passes;
            end
            w_cnt     <= (state == LOAD_W && !last_w) ? w_cnt + 1'b1 : '0;
            row       <= (streaming && !last_row) ? row + 1'b1 : '0;
            i_addr    <= (streaming && !last_row) ?
                         (i_addr == IA_W'(I_ROWS - 1) ? '0 : i_addr + 1'b1) : '0;
            seg       <= state == LOAD_W ? 4'd0 : (state == RUN && last_row) ? seg + 4'd1 : seg;
            tg        <= state == RUN && !tg;
            w_valid_q <= state == LOAD_W;
            i_valid_q <= streaming;
            ctrl_q    <= ctrl_n;
            wgroup_q  <= wgroup_n;
            wround_q  <= wround_n;
            done_q    <= state == WAIT_FIN && ipf_finish;
        end

`ifdef IPF_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perf_cycles <= '0;
            perf_rows   <= '0;
        end else begin
            perf_cycles <= accept ? '0 : busy ? perf_cycles + 32'd1 : perf_cycles;
            perf_rows   <= accept ? '0 : i_valid_q ? perf_rows + 16'd1 : perf_rows;
        end
`endif

    // SRAM read data is already one cycle behind its address, so it passes straight through
    assign ipf_w_data  = w_valid_q ? w_rd_data : '0;
    assign ipf_i_data  = i_valid_q ? i_rd_data : '0;
    assign ipf_w_valid = w_valid_q;
    assign ipf_i_valid = i_valid_q;
    assign ipf_ctrl    = ctrl_q;
    assign ipf_wgroup  = wgroup_q;
    assign ipf_wround  = wround_q;
    assign ipf_wsize   = {1'b0, k5};
    assign ipf_stride  = stride_r;
    assign w_rd_addr   = w_cnt;
    assign i_rd_addr   = i_addr;
    assign cfg_ready   = state == IDLE;
    assign busy        = state != IDLE;
    assign done        = done_q;
endmodule

// File: tb/tb_ipf_seq.sv
// tb_ipf_seq: directed bench for ipf_seq with sync-read SRAM models.
// Define IPF_SEQ_PERF_EN on both files to also check the perf counters.
module tb_ipf_seq;
    logic        clk, rst, cfg_valid, cfg_ready, cfg_stride;
    logic [1:0]  cfg_wsize, ipf_ctrl, ipf_wsize;
    logic [3:0]  cfg_segs, cfg_passes, ipf_wgroup;
    logic [4:0]  w_rd_addr;
    logic [2:0]  i_rd_addr, ipf_wround;
    logic [63:0] w_rd_data, i_rd_data, ipf_w_data, ipf_i_data;
    logic        ipf_w_valid, ipf_i_valid, ipf_stride, ipf_finish, busy, done;
`ifdef IPF_SEQ_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_rows;
`endif

    ipf_seq dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride), .cfg_segs(cfg_segs),
        .cfg_passes(cfg_passes), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data), .ipf_ctrl(ipf_ctrl),
        .ipf_w_valid(ipf_w_valid), .ipf_w_data(ipf_w_data), .ipf_i_valid(ipf_i_valid),
        .ipf_i_data(ipf_i_data), .ipf_wsize(ipf_wsize), .ipf_stride(ipf_stride),
        .ipf_wgroup(ipf_wgroup), .ipf_wround(ipf_wround), .ipf_finish(ipf_finish),
        .busy(busy), .done(done)
`ifdef IPF_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_rows(perf_rows)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read SRAMs: word content encodes its own address
    always @(posedge clk) begin
        w_rd_data <= 64'h2000 + 64'(w_rd_addr);
        i_rd_data <= 64'h1000 + 64'(i_rd_addr);
    end

    int errs = 0, n_chk = 0;
    int cyc = 0, last_w = 0, first_i = 0, last_i = 0, busy_n = 0, done_n = 0;
    logic [63:0] wq[$], dq[$];
    logic [1:0]  cq[$];
    logic [3:0]  gq[$];
    logic [2:0]  rq[$];

    always @(negedge clk) begin
        cyc++;
        if (ipf_w_valid) begin
            wq.push_back(ipf_w_data);
            last_w = cyc;
        end
        if (ipf_i_valid) begin
            if (dq.size() == 0) first_i = cyc;
            last_i = cyc;
            dq.push_back(ipf_i_data);
            cq.push_back(ipf_ctrl);
            gq.push_back(ipf_wgroup);
            rq.push_back(ipf_wround);
        end
        if (busy) busy_n++;
        if (done) done_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic run_job(input int ws, input int st, input int sg, input int ps, input bit inj);
        int k5, st_e, sg_e, ps_e, p, total, nb, nw, n, s, r;
        int bw, bc, bg, br, bd;
        k5 = (ws == 1);
        st_e = (st != 0 && k5 == 0);
        sg_e = sg == 0 ? 1 : sg;
        ps_e = ps == 0 ? 1 : ps;
        p = k5 ? 4 : 2;
        total = ps_e * 8;
        nb = sg_e * total;
        nw = k5 ? 25 : 18;
        wq.delete(); dq.delete(); cq.delete(); gq.delete(); rq.delete();
        busy_n = 0; done_n = 0;
        cfg_wsize = 2'(ws); cfg_stride = st[0]; cfg_segs = 4'(sg); cfg_passes = 4'(ps);
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        chk("busy_after_cfg", busy, 1);
        chk("cfg_ready_busy", cfg_ready, 0);
        chk("ipf_wsize", ipf_wsize, 64'(k5));
        chk("ipf_stride", ipf_stride, 64'(st_e));
        if (inj) begin
            repeat (3) tick;
            ipf_finish = 1'b1;
            tick;
            ipf_finish = 1'b0;
        end
        n = 0;
        while (ipf_ctrl != 2'd0 && n < 3000) begin
            cfg_valid = 1'b0;
            if (inj && n == 30) begin
                cfg_valid = 1'b1; cfg_wsize = 2'd1; cfg_segs = 4'd7; cfg_passes = 4'd3;
            end
            tick;
            n++;
        end
        cfg_valid = 1'b0;
        chk("end_ctrl", ipf_ctrl, 0);
        chk("end_valid", ipf_i_valid, 0);
        chk("early_done", done_n, 0);
        repeat (2) tick;
        chk("wait_fin_busy", busy, 1);
        ipf_finish = 1'b1;
        tick;
        ipf_finish = 1'b0;
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
`ifdef IPF_SEQ_PERF_EN
        chk("perf_rows", perf_rows, 64'(nb));
        chk("perf_cycles", perf_cycles, 64'(busy_n));
`endif
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_ctrl", ipf_ctrl, 3);
        chk("idle_ready", cfg_ready, 1);
        chk("w_beats", wq.size(), 64'(nw));
        bw = 0;
        foreach (wq[i]) if (wq[i] !== 64'h2000 + 64'(i)) bw++;
        chk("w_data_bad", bw, 0);
        chk("i_beats", dq.size(), 64'(nb));
        chk("first_i_follows_w", first_i, 64'(last_w + 1));
        chk("i_no_bubble", last_i - first_i + 1, 64'(nb));
        bc = 0; bg = 0; br = 0; bd = 0;
        foreach (dq[b]) begin
            s = b / total;
            r = b % total;
            if (cq[b] !== 2'(r < p ? (s == 0 ? 3 : 2) : 1)) bc++;
            if (gq[b] !== 4'(k5 ? 0 : st_e ? (r < p ? 0 : (r - p) % 2) : s)) bg++;
            if (rq[b] !== 3'(k5 ? s % 2 : 0)) br++;
            if (dq[b] !== 64'h1000 + 64'(r % 8)) bd++;
        end
        chk("ctrl_bad", bc, 0);
        chk("wgroup_bad", bg, 0);
        chk("wround_bad", br, 0);
        chk("i_addr_bad", bd, 0);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_wsize = 2'd0; cfg_stride = 1'b0;
        cfg_segs = 4'd0; cfg_passes = 4'd0; ipf_finish = 1'b0;
        repeat (3) tick;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ctrl", ipf_ctrl, 3);
        chk("rst_ivalid", ipf_i_valid, 0);
        chk("rst_wvalid", ipf_w_valid, 0);
        chk("rst_wgroup", ipf_wgroup, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick;
        run_job(0, 0, 2, 2, 1'b0);
        run_job(1, 0, 4, 1, 1'b0);
        run_job(0, 1, 1, 1, 1'b0);
        run_job(0, 0, 2, 2, 1'b1);
        run_job(2, 1, 0, 0, 1'b0);
        cfg_wsize = 2'd0; cfg_stride = 1'b0; cfg_segs = 4'd2; cfg_passes = 4'd2;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        repeat (25) tick;
        chk("pre_rst_running", ipf_i_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ctrl", ipf_ctrl, 3);
        chk("mid_rst_ivalid", ipf_i_valid, 0);
        chk("mid_rst_idata", ipf_i_data, 0);
        chk("mid_rst_iaddr", i_rd_addr, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        tick;
        rst = 1'b0;
        tick;
        run_job(1, 0, 1, 1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end
endmodule
